// File: rtl/uart_rx_ctrl_if.sv
// Host-side handshake bundle for the UART receive controller: FIFO head,
// valid/ready pop and the sticky status flags.
interface uart_rx_ctrl_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       frame_err;
    logic       overflow;
    logic       clear_flags;

    modport master (
        input  rd_data, rd_valid, frame_err, overflow,
        output rd_ready, clear_flags
    );

    modport slave (
        output rd_data, rd_valid, frame_err, overflow,
        input  rd_ready, clear_flags
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, frame tracker that mirrors
// the receiver's counters, and a first-word fall-through byte FIFO for the host.
module uart_rx_ctrl #(
    parameter int DIV_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rx_line,
    input  logic [7:0]       rx_data,
    output logic             rx_en,
    output logic             busy,
    uart_rx_ctrl_if.slave    host
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {HUNT, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       samp_q, samp_d;
    logic [2:0]       bit_q, bit_d;
    logic             cap_q, cap_d;
    logic             run_q, run_d;
    logic [DIV_W-1:0] divcnt_q, divcnt_d;
    logic             rx_en_q, rx_en_d;
    logic             ferr_q, ferr_d, ferr_set;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]       mem_q [DEPTH];

    logic empty, full, pop, push, drop;

    // >= rather than == so a divisor lowered while idle cannot strand the counter
    always_comb begin
        run_d = (state_q == HUNT) ? enable : 1'b1;
        divcnt_d = '0;
        rx_en_d = 1'b0;
        if (run_q) begin
            if (divcnt_q >= baud_div) begin
                rx_en_d = 1'b1;
            end else begin
                divcnt_d = divcnt_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        samp_d   = samp_q;
        bit_d    = bit_q;
        cap_d    = 1'b0;
        ferr_set = 1'b0;
        if (rx_en_q) begin
            unique case (state_q)
                HUNT: begin
                    if (rx_line) begin
                        samp_d = '0;
                    end else if (samp_q == 4'd7) begin
                        state_d = DATA;
                        samp_d  = '0;
                        bit_d   = '0;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                DATA: begin
                    if (samp_q == 4'd15) begin
                        samp_d = '0;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            cap_d   = 1'b1;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                STOP: begin
                    if (samp_q == 4'd7 && !rx_line) ferr_set = 1'b1;
                    if (samp_q == 4'd15) begin
                        state_d = HUNT;
                        samp_d  = '0;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    samp_d  = '0;
                end
            endcase
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && host.rd_ready;
    assign push  = cap_q && (!full || pop);
    assign drop  = cap_q && full && !pop;

    always_comb begin
        wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        ferr_d = ferr_set || (ferr_q && !host.clear_flags);
        ovf_d  = drop || (ovf_q && !host.clear_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            samp_q   <= '0;
            bit_q    <= '0;
            cap_q    <= 1'b0;
            run_q    <= 1'b0;
            divcnt_q <= '0;
            rx_en_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            samp_q   <= samp_d;
            bit_q    <= bit_d;
            cap_q    <= cap_d;
            run_q    <= run_d;
            divcnt_q <= divcnt_d;
            rx_en_q  <= rx_en_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            if (push) mem_q[wptr_q[AW-1:0]] <= rx_data;
        end
    end

    assign rx_en          = rx_en_q;
    assign busy           = (state_q != HUNT);
    assign host.rd_data   = mem_q[rptr_q[AW-1:0]];
    assign host.rd_valid  = !empty;
    assign host.frame_err = ferr_q;
    assign host.overflow  = ovf_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives tick-aligned serial frames and a
// receiver data_out model, checking against a queue-based FIFO/flag model.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] baud_div = '0;
    logic        rx_line = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_en;
    logic        busy;

    uart_rx_ctrl_if hif ();

    uart_rx_ctrl #(.DIV_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .baud_div(baud_div),
        .rx_line(rx_line), .rx_data(rx_data), .rx_en(rx_en), .busy(busy),
        .host(hif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic exp_ferr = 1'b0;
    logic exp_ovf = 1'b0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line level for tick t of a frame, aligned to the tracker's windows:
    // 8 start ticks, 128 data ticks (16 per bit, LSB first), 16 stop ticks.
    function automatic logic level(input int t, input logic [7:0] b, input logic stop);
        if (t <= 8) return 1'b0;
        if (t <= 136) return b[3'((t - 9) / 16)];
        if (t <= 152) return stop;
        return 1'b1;
    endfunction

    task automatic model_push(input logic [7:0] b, input logic stop);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        if (!stop) exp_ferr = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit chk_lat,
                              input int drop_at, input int abort_at,
                              input bit pop_at_cap, input bit clr_at_err);
        int t = 0;
        int since = -1;
        int cyc = 0;
        bit cl_pending = 0;
        bit aborted = 0;
        rx_data = ~b;
        while (t < 152 && cyc < 20000 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (cl_pending) begin
                hif.clear_flags = 1'b0;
                cl_pending = 0;
                checks++;
                if (hif.frame_err !== 1'b1) begin
                    errors++;
                    $display("FAIL set_beats_clear: frame_err=%b want 1", hif.frame_err);
                end
            end
            if (since >= 0) since++;
            if (since == 1) begin
                if (pop_at_cap) hif.rd_ready = 1'b1;
                if (chk_lat) begin
                    checks++;
                    if (hif.rd_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL cap_latency: rd_valid=%b in cap cycle want 0", hif.rd_valid);
                    end
                end
            end
            if (since == 2) begin
                if (pop_at_cap) hif.rd_ready = 1'b0;
                if (chk_lat) begin
                    checks++;
                    if (hif.rd_valid !== 1'b1 || hif.rd_data !== b) begin
                        errors++;
                        $display("FAIL valid_latency: rd_valid=%b rd_data=%h want 1/%h",
                                 hif.rd_valid, hif.rd_data, b);
                    end
                end
            end
            if (rx_en) begin
                t++;
                if (t == abort_at) begin
                    aborted = 1;
                end else begin
                    rx_line = level(t, b, stop);
                    if (t == 8) begin
                        checks++;
                        if (busy !== 1'b0) begin
                            errors++;
                            $display("FAIL busy_hunt: busy=%b at tick 8 want 0", busy);
                        end
                    end
                    if (t == 9) begin
                        checks++;
                        if (busy !== 1'b1) begin
                            errors++;
                            $display("FAIL busy_data: busy=%b at tick 9 want 1", busy);
                        end
                    end
                    if (t == drop_at) enable = 1'b0;
                    if (t == 136) begin
                        rx_data = b;
                        since = 0;
                    end
                    if (clr_at_err && t == 144) begin
                        hif.clear_flags = 1'b1;
                        cl_pending = 1;
                    end
                end
            end
        end
        if (!aborted) begin
            checks++;
            if (cyc >= 20000) begin
                errors++;
                $display("FAIL frame_timeout: reached tick %0d want 152", t);
            end else begin
                @(negedge clk);
                rx_line = 1'b1;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_end: busy=%b after stop want 0", busy);
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_en, busy, hif.rd_valid, hif.frame_err, hif.overflow} !== 5'b0 ||
            hif.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: en/busy/valid/ferr/ovf=%b rd_data=%h want 00000/00",
                     {rx_en, busy, hif.rd_valid, hif.frame_err, hif.overflow}, hif.rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tick_rate;
        int n;
        int k;
        baud_div = 16'd0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_en) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL tick_div0: %0d ticks in 20 cycles want 20", n);
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_en) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL tick_stopped: %0d ticks with enable=0 want 0", n);
        end
        // one edge latches run, then baud_div+1 counting edges from divcnt=0
        baud_div = 16'd5;
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rx_en && k < 50);
        checks++;
        if (k !== 7) begin
            errors++;
            $display("FAIL tick_first: first tick after %0d cycles want 7", k);
        end
        n = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (rx_en !== ((i % 6) == 0)) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL tick_div5: %0d cycles off the 6-cycle pattern want 0", n);
        end
    endtask

    task automatic test_single;
        baud_div = 16'd3;
        enable = 1'b1;
        @(negedge clk);
        send_frame(8'hA5, 1'b1, 1, 0, 0, 0, 0);
        model_push(8'hA5, 1'b1);
        checks++;
        if (hif.frame_err !== 1'b0 || hif.rd_data !== exp_q[0]) begin
            errors++;
            $display("FAIL single_byte: ferr=%b data=%h want 0/%h", hif.frame_err, hif.rd_data, exp_q[0]);
        end
        hif.rd_ready = 1'b1;
        @(negedge clk);
        hif.rd_ready = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (hif.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: rd_valid=%b want 0", hif.rd_valid);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] v;
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i * 8'h11);
            send_frame(v, 1'b1, 0, 0, 0, 0, 0);
            model_push(v, 1'b1);
        end
        checks++;
        if (hif.overflow !== exp_ovf || hif.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: ovf=%b valid=%b want %b/1", hif.overflow, hif.rd_valid, exp_ovf);
        end
        for (int phase = 0; phase < 2; phase++) begin
            hif.rd_ready = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (hif.rd_valid !== 1'b1 || hif.rd_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL overflow_drain%0d: valid=%b data=%h want 1/%h",
                             phase, hif.rd_valid, hif.rd_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                @(negedge clk);
            end
            hif.rd_ready = 1'b0;
            checks++;
            if (hif.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL overflow_empty%0d: rd_valid=%b want 0", phase, hif.rd_valid);
            end
            if (phase == 0) begin
                hif.clear_flags = 1'b1;
                @(negedge clk);
                hif.clear_flags = 1'b0;
                exp_ovf = 1'b0;
                checks++;
                if (hif.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_clear: ovf=%b want 0", hif.overflow);
                end
                for (int i = 0; i < DEPTH; i++) begin
                    v = 8'($urandom);
                    send_frame(v, 1'b1, 0, 0, 0, 0, 0);
                    model_push(v, 1'b1);
                end
                v = 8'($urandom);
                send_frame(v, 1'b1, 0, 0, 0, 1, 0);
                void'(exp_q.pop_front());
                exp_q.push_back(v);
                checks++;
                if (hif.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL push_with_pop: ovf=%b want 0", hif.overflow);
                end
            end
        end
    endtask

    task automatic test_frame_err;
        send_frame(8'h3C, 1'b0, 0, 0, 0, 0, 0);
        model_push(8'h3C, 1'b0);
        checks++;
        if (hif.frame_err !== 1'b1 || hif.rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL frame_err: ferr=%b data=%h want 1/3c", hif.frame_err, hif.rd_data);
        end
        hif.clear_flags = 1'b1;
        @(negedge clk);
        hif.clear_flags = 1'b0;
        checks++;
        if (hif.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear: ferr=%b want 0", hif.frame_err);
        end
        send_frame(8'hE1, 1'b0, 0, 0, 0, 0, 1);
        model_push(8'hE1, 1'b0);
        hif.rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hif.rd_valid !== 1'b1 || hif.rd_data !== exp_q[0]) begin
                errors++;
                $display("FAIL ferr_data: valid=%b data=%h want 1/%h", hif.rd_valid, hif.rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        hif.rd_ready = 1'b0;
        hif.clear_flags = 1'b1;
        @(negedge clk);
        hif.clear_flags = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic test_glitch;
        int t = 0;
        int cyc = 0;
        int nbusy = 0;
        int nvalid = 0;
        while (t < 46 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            if (hif.rd_valid) nvalid++;
            if (rx_en) begin
                t++;
                rx_line = (t > 5);
            end
        end
        rx_line = 1'b1;
        checks++;
        if (nbusy !== 0 || nvalid !== 0 || t !== 46) begin
            errors++;
            $display("FAIL glitch: busy cycles=%0d valid cycles=%0d ticks=%0d want 0/0/46", nbusy, nvalid, t);
        end
        send_frame(8'h5A, 1'b1, 1, 0, 0, 0, 0);
        model_push(8'h5A, 1'b1);
        hif.rd_ready = 1'b1;
        @(negedge clk);
        hif.rd_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic test_enable_drop;
        int n = 0;
        send_frame(8'hC3, 1'b1, 0, 20, 0, 0, 0);
        model_push(8'hC3, 1'b1);
        checks++;
        if (hif.rd_valid !== 1'b1 || hif.rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL enable_drop_data: valid=%b data=%h want 1/c3", hif.rd_valid, hif.rd_data);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (rx_en) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL enable_drop_stop: %0d ticks after frame want 0", n);
        end
        hif.rd_ready = 1'b1;
        @(negedge clk);
        hif.rd_ready = 1'b0;
        void'(exp_q.pop_front());
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int nbad = 0;
        send_frame(8'h77, 1'b0, 0, 0, 0, 0, 0);
        model_push(8'h77, 1'b0);
        send_frame(8'h99, 1'b1, 0, 0, 60, 0, 0);
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({rx_en, busy, hif.rd_valid, hif.frame_err, hif.overflow} !== 5'b0 ||
            hif.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: en/busy/valid/ferr/ovf=%b rd_data=%h want 00000/00",
                     {rx_en, busy, hif.rd_valid, hif.frame_err, hif.overflow}, hif.rd_data);
        end
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
        rx_line = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy || hif.rd_valid) nbad++;
        end
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL reset_no_push: %0d cycles busy/valid after reset want 0", nbad);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        logic s;
        for (int f = 0; f < 8; f++) begin
            baud_div = 16'($urandom_range(0, 3));
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s, 0, 0, 0, 0, 0);
            model_push(b, s);
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
                checks++;
                if (hif.rd_valid !== 1'b1 || hif.rd_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_pop%0d: valid=%b data=%h want 1/%h", f, hif.rd_valid, hif.rd_data, exp_q[0]);
                end
                hif.rd_ready = 1'b1;
                @(negedge clk);
                hif.rd_ready = 1'b0;
                void'(exp_q.pop_front());
            end
        end
        checks++;
        if (hif.frame_err !== exp_ferr || hif.overflow !== exp_ovf) begin
            errors++;
            $display("FAIL b2b_flags: ferr=%b ovf=%b want %b/%b", hif.frame_err, hif.overflow, exp_ferr, exp_ovf);
        end
        hif.rd_ready = 1'b1;
        while (exp_q.size() > 0) begin
            checks++;
            if (hif.rd_valid !== 1'b1 || hif.rd_data !== exp_q[0]) begin
                errors++;
                $display("FAIL b2b_drain: valid=%b data=%h want 1/%h", hif.rd_valid, hif.rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        hif.rd_ready = 1'b0;
        checks++;
        if (hif.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: rd_valid=%b want 0", hif.rd_valid);
        end
    endtask

    initial begin
        hif.rd_ready = 1'b0;
        hif.clear_flags = 1'b0;
        test_reset();
        test_tick_rate();
        test_single();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
